// File: rtl/clk_div_pkg.sv
// Shared definitions for the programmable clock divider: minimum legal ratio,
// FSM state encoding and the half-ratio helper used for phase timing.
package clk_div_pkg;

    localparam int unsigned DIV_MIN = 2;

    typedef enum logic {
        IDLE = 1'b0,
        RUN  = 1'b1
    } state_e;

    function automatic int unsigned half_floor(input int unsigned n);
        return n >> 1;
    endfunction

endpackage

// File: rtl/clk_div_prog_if.sv
// Control/status bundle of clk_div_prog; master = controller, slave = divider.
interface clk_div_prog_if #(
    parameter int unsigned DIV_W = 8
) ();
    import clk_div_pkg::*;

    // div_load is a single-cycle request with no back-pressure: it is taken on
    // the rising edge where it is high, and answered later by a one-cycle
    // div_ack (ratio became active) or immediately by a one-cycle div_err.
    logic             div_en;
    logic             div_load;
    logic [DIV_W-1:0] div_val;
    logic             div_ack;
    logic             div_err;
    logic             clk_out;
    logic             clk_stb;
    state_e           dbg_state;

    modport master (
        output div_en, div_load, div_val,
        input  div_ack, div_err, clk_out, clk_stb, dbg_state
    );

    modport slave (
        input  div_en, div_load, div_val,
        output div_ack, div_err, clk_out, clk_stb, dbg_state
    );

endinterface

// File: rtl/clk_div_half_stretch.sv
// Falling-edge re-sample of the high phase; stretches clk_out by half a
// sys_clk period for odd ratios. Holds the design's only negedge flop.
module clk_div_half_stretch (
    input  logic clk,
    input  logic rst_n,
    input  logic rise_i,
    input  logic odd_i,
    output logic clk_o
);

    logic fall_d;
    logic fall_q;

    always_comb fall_d = rise_i;

    always_ff @(negedge clk or negedge rst_n) begin
        if (!rst_n) begin
            fall_q <= 1'b0;
        end else begin
            fall_q <= fall_d;
        end
    end

    assign clk_o = rise_i | (fall_q & odd_i);

endmodule

// File: rtl/clk_div_prog.sv
// Programmable 50 % duty integer clock divider with glitch-free ratio handover.
// Optional macro CLK_DIV_STB_EN enables the sys_clk-domain period-start strobe.
module clk_div_prog
    import clk_div_pkg::*;
#(
    parameter int unsigned DIV_W       = 8,
    parameter int unsigned DIV_DEFAULT = 5
) (
    input  logic          sys_clk,
    input  logic          sys_rst_n,
    clk_div_prog_if.slave bus
);

    localparam logic [DIV_W-1:0] ONE = DIV_W'(1);

    state_e           state_q, state_d;
    logic [DIV_W-1:0] act_q, act_d;
    logic [DIV_W-1:0] pend_q, pend_d;
    logic             pend_vld_q, pend_vld_d;
    logic [DIV_W-1:0] cnt_q, cnt_d;
    logic             rise_q, rise_d;
    logic             ack_q, ack_d;
    logic             err_q, err_d;

    logic             load_ok;
    logic             wrap;
    logic             start;
    logic [DIV_W-1:0] n_eff;
    logic [DIV_W-1:0] cnt_inc;

    always_comb begin
        load_ok = bus.div_load && (32'(bus.div_val) >= DIV_MIN);
        wrap    = (cnt_q == act_q - ONE);
        n_eff   = pend_vld_q ? pend_q : act_q;
        cnt_inc = cnt_q + ONE;
        start   = bus.div_en && ((state_q == IDLE) || wrap);

        state_d = state_q;
        act_d   = act_q;
        cnt_d   = cnt_q;
        rise_d  = rise_q;

        // A period start swaps in the pending ratio; a wrap without enable
        // parks the divider low so no phase is ever truncated.
        if (start) begin
            state_d = RUN;
            act_d   = n_eff;
            cnt_d   = '0;
            rise_d  = (half_floor(32'(n_eff)) != 0);
        end else if (state_q == RUN) begin
            if (wrap) begin
                state_d = IDLE;
                cnt_d   = '0;
                rise_d  = 1'b0;
            end else begin
                cnt_d  = cnt_inc;
                rise_d = (32'(cnt_inc) < half_floor(32'(act_q)));
            end
        end

        // A load on a start edge stays pending; the older value was consumed.
        pend_d     = load_ok ? bus.div_val : pend_q;
        pend_vld_d = load_ok ? 1'b1 : (start ? 1'b0 : pend_vld_q);
        ack_d      = start && pend_vld_q;
        err_d      = bus.div_load && !load_ok;
    end

    always_ff @(posedge sys_clk or negedge sys_rst_n) begin
        if (!sys_rst_n) begin
            state_q    <= IDLE;
            act_q      <= DIV_W'(DIV_DEFAULT);
            pend_q     <= '0;
            pend_vld_q <= 1'b0;
            cnt_q      <= '0;
            rise_q     <= 1'b0;
            ack_q      <= 1'b0;
            err_q      <= 1'b0;
        end else begin
            state_q    <= state_d;
            act_q      <= act_d;
            pend_q     <= pend_d;
            pend_vld_q <= pend_vld_d;
            cnt_q      <= cnt_d;
            rise_q     <= rise_d;
            ack_q      <= ack_d;
            err_q      <= err_d;
        end
    end

    clk_div_half_stretch u_stretch (
        .clk    (sys_clk),
        .rst_n  (sys_rst_n),
        .rise_i (rise_q),
        .odd_i  (act_q[0]),
        .clk_o  (bus.clk_out)
    );

`ifdef CLK_DIV_STB_EN
    logic stb_d;
    logic stb_q;

    always_comb stb_d = start;

    always_ff @(posedge sys_clk or negedge sys_rst_n) begin
        if (!sys_rst_n) begin
            stb_q <= 1'b0;
        end else begin
            stb_q <= stb_d;
        end
    end

    assign bus.clk_stb = stb_q;
`else
    assign bus.clk_stb = 1'b0;
`endif

    assign bus.div_ack   = ack_q;
    assign bus.div_err   = err_q;
    assign bus.dbg_state = state_q;

endmodule
